uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Transmit-side buffer that sits directly upstream of the uart top-level TX path.
- Accepts bytes from a host/bus at clock rate and stores them in a DEPTH-entry FIFO.
- Drains the FIFO one byte at a time into the transmitter: issues a one-cycle tx_en with a stable tx_data, then waits for tx_done before sending the next byte.
- Decouples bursty producers from the slow serial line.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two, at least 2.
- ADDR_W, 4, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  host write strobe; one byte per cycle.
- wr_data  input  8  byte to enqueue.
- ovf_clr  input  1  clears the sticky overflow flag.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when a write is dropped.
- tx_en  output  1  one-cycle start pulse to the transmitter.
- tx_data  output  8  byte under transmission; held stable from tx_en until tx_done.
- tx_done  input  1  one-cycle pulse from the transmitter at the end of the stop bit.

Behaviour:
- Reset (async, rst_n low):
  - wr_ptr = rd_ptr = 0, count = 0, so empty = 1 and full = 0.
  - overflow = 0, tx_en = 0, tx_data = 8'h00, FSM = IDLE.
  - Memory contents are don't-care.
- Reset mid-transmission: everything above clears immediately and the queued bytes are discarded. The transmitter shares rst_n, so no partial handshake survives.
- Storage: circular buffer indexed by ADDR_W-bit pointers that wrap naturally DEPTH-1 -> 0. count is a separate (ADDR_W+1)-bit register.
- full, empty and count are registered values, updated on the edge after a push or pop.
- Write acceptance:
  - A write is accepted when wr_en = 1 and full = 0, sampled on the registered full.
  - On acceptance: mem[wr_ptr] <= wr_data and wr_ptr increments.
- Write when full:
  - The byte is dropped, pointers are unchanged, and overflow <= 1.
  - This holds even if a pop happens in the same cycle; the write is still rejected.
- overflow flag:
  - Cleared by ovf_clr.
  - If a drop and ovf_clr occur in the same cycle, set wins (overflow stays 1).
- Push and pop in the same cycle: count unchanged, both pointers advance.
- FSM, 3 states:
  - IDLE: if empty = 0, pop: tx_data <= mem[rd_ptr], rd_ptr increments, count decrements; next state START. Otherwise stay in IDLE.
  - START: tx_en = 1 for exactly this one cycle; next state WAIT.
  - WAIT: tx_en = 0, tx_data held. On tx_done = 1, go to IDLE. Otherwise stay.
- tx_done seen in IDLE or START is ignored and has no effect.
- tx_en is a registered output: it is high exactly while the FSM is in START.
- Latency: a write at edge N to an empty, idle FIFO gives empty = 0 after N, the pop at N+1, and tx_en high during the cycle after N+1.
- Back-to-back bytes: minimum gap from a tx_done pulse to the next tx_en is 2 cycles (tx_done -> IDLE, IDLE -> START).
- Ordering: strict FIFO; the byte that left the queue at the pop is the one presented on tx_data.
- Count arithmetic: count never exceeds DEPTH and never underflows. A pop is only performed when empty = 0; a push only when full = 0.

Test Plan:
- Single byte: reset, write 8'hA5 once -> count goes 1 then 0, tx_en pulses once with tx_data = 8'hA5. Drive tx_done 20 cycles later -> FSM back to IDLE, tx_data still 8'hA5, empty = 1.
- Burst ordering: write 8'h11, 8'h22, 8'h33 on consecutive cycles, and answer each tx_en with tx_done 10 cycles later -> exactly three tx_en pulses with data 11, 22, 33 in order, each separated by at least 12 cycles.
- Fill and overflow: hold the transmitter busy (no tx_done) and write 18 bytes 0x00..0x11 -> count saturates at 16 (first byte popped, so 16 stored), full = 1, overflow = 1. Assert ovf_clr -> overflow = 0. Drain -> output sequence 0x00..0x10; byte 0x11 is never sent.
- Simultaneous push/pop: with count = 3 and the FSM entering IDLE, assert wr_en in the pop cycle -> count stays 3 and the pointers wrap correctly across index 15 -> 0 over 20 total bytes with no corruption.
- Reset mid-operation: 5 bytes queued, FSM in WAIT, pull rst_n low asynchronously between edges -> tx_en = 0, tx_data = 0, count = 0, empty = 1 immediately. After release, no tx_en until a new write.
- Spurious tx_done: pulse tx_done while in IDLE with empty = 1, and during START -> no state change, no pop, no extra tx_en.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding a UART transmitter: buffers host writes and hands
// bytes out one at a time with a tx_en pulse, waiting for tx_done between bytes.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              ovf_clr,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              tx_en,
    output logic [7:0]        tx_data,
    input  logic              tx_done
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state_q;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, empty_q, overflow_q, overflow_d;
    logic              tx_en_q;
    logic [7:0]        tx_data_q;
    logic              push, pop;

    // Acceptance decisions use only registered flags, so a pop in the same
    // cycle never rescues a write against a full buffer.
    assign push = wr_en && !full_q;
    assign pop  = (state_q == S_IDLE) && !empty_q;

    always_comb begin
        count_d    = count_q + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
        overflow_d = overflow_q;
        if (ovf_clr)
            overflow_d = 1'b0;
        if (wr_en && full_q)
            overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            full_q     <= (count_d == FULL_CNT);
            empty_q    <= (count_d == '0);
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_en_q <= 1'b0;
                    if (pop) begin
                        tx_data_q <= mem[rd_ptr_q];
                        tx_en_q   <= 1'b1;
                        state_q   <= S_START;
                    end
                end
                S_START: begin
                    tx_en_q <= 1'b0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    tx_en_q <= 1'b0;
                    if (tx_done)
                        state_q <= S_IDLE;
                end
                default: begin
                    tx_en_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign tx_en    = tx_en_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: cycle table for the basic handshake, then scoreboarded
// sequences for bursts, overflow, wrap-around with simultaneous push/pop and reset.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       ovf_clr = 1'b0;
    logic       full, empty, overflow, tx_en, tx_done;
    logic [4:0] count;
    logic [7:0] tx_data;

    logic manual_done = 1'b0;
    logic auto_done   = 1'b0;
    assign tx_done = manual_done | auto_done;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int n_txen  = 0;
    logic [7:0] sb[$];
    logic mon_en = 1'b0;
    logic gap_chk = 1'b0;
    int   last_txen = -1;
    logic auto_en = 1'b0;
    int   done_delay = 10;
    logic pending = 1'b0;
    int   wcnt = 0;

    uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .ovf_clr(ovf_clr), .full(full), .empty(empty), .count(count),
        .overflow(overflow), .tx_en(tx_en), .tx_data(tx_data), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every tx_en pulse must match the oldest expected byte.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (tx_en) begin
            n_txen++;
            if (mon_en) begin
                if (sb.size() == 0) begin
                    check("unexpected_tx_en", 32'(tx_data), 32'hFFFF_FFFF);
                end else begin
                    check("tx_order", 32'(tx_data), 32'(sb.pop_front()));
                end
                if (gap_chk && last_txen >= 0)
                    check("tx_gap_ge12", 32'(cyc - last_txen >= 12), 32'd1);
            end
            last_txen = cyc;
        end
    end

    // Transmitter model: answers each tx_en with a one-cycle tx_done.
    always @(posedge clk) begin
        #1;
        auto_done = 1'b0;
        if (!rst_n) begin
            pending = 1'b0;
        end else if (tx_en && auto_en) begin
            pending = 1'b1;
            wcnt = 0;
        end else if (pending && auto_en) begin
            wcnt++;
            if (wcnt >= done_delay) begin
                auto_done = 1'b1;
                pending = 1'b0;
            end
        end
    end

    task automatic step(input logic we, input logic [7:0] wd, input logic td, input logic oc);
        @(negedge clk);
        wr_en = we; wr_data = wd; manual_done = td; ovf_clr = oc;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic accepted);
        step(1'b1, d, 1'b0, 1'b0);
        if (accepted) sb.push_back(d);
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (sb.size() == 0) break;
            idle(1);
        end
        check("drain_complete", 32'(sb.size()), 32'd0);
        idle(15);
    endtask

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       td;
        logic       oc;
        logic [4:0] cnt;
        logic       emp;
        logic       ful;
        logic       ovf;
        logic       ten;
        logic [7:0] tdat;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
        tbl[5]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C};
        tbl[8]  = '{1'b1, 8'h77, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h77};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h77};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h77};

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_tx_en", 32'(tx_en), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Cycle table: single byte, spurious tx_done in IDLE and START
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].we, tbl[i].wd, tbl[i].td, tbl[i].oc);
            check($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            check($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].emp));
            check($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].ful));
            check($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
            check($sformatf("tbl%0d_tx_en", i), 32'(tx_en), 32'(tbl[i].ten));
            check($sformatf("tbl%0d_tx_data", i), 32'(tx_data), 32'(tbl[i].tdat));
        end
        idle(2);

        // Burst ordering with a 10-cycle transmitter
        mon_en = 1'b1;
        auto_en = 1'b1;
        done_delay = 10;
        gap_chk = 1'b1;
        last_txen = -1;
        begin
            int base;
            base = n_txen;
            write_byte(8'h11, 1'b1);
            write_byte(8'h22, 1'b1);
            write_byte(8'h33, 1'b1);
            idle(1);
            wait_drain(200);
            check("burst_pulses", 32'(n_txen - base), 32'd3);
        end
        gap_chk = 1'b0;
        check("burst_empty", 32'(empty), 32'd1);

        // Fill and overflow with the transmitter stalled
        auto_en = 1'b0;
        for (int i = 0; i < 18; i++)
            write_byte(8'(i), (i < 17) ? 1'b1 : 1'b0);
        idle(1);
        check("fill_count", 32'(count), 32'd16);
        check("fill_full", 32'(full), 32'd1);
        check("fill_empty", 32'(empty), 32'd0);
        check("fill_ovf", 32'(overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_cleared", 32'(overflow), 32'd0);
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        check("ovf_set_wins", 32'(overflow), 32'd1);
        check("ovf_drop_count", 32'(count), 32'd16);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_cleared2", 32'(overflow), 32'd0);
        auto_en = 1'b1;
        done_delay = 4;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        wait_drain(600);
        check("fill_drained_count", 32'(count), 32'd0);
        check("fill_drained_empty", 32'(empty), 32'd1);

        // Simultaneous push/pop and pointer wrap
        auto_en = 1'b0;
        for (int i = 0; i < 4; i++) write_byte(8'h80 + 8'(i), 1'b1);
        idle(2);
        check("pp_count_pre", 32'(count), 32'd3);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("pp_count_idle", 32'(count), 32'd3);
        check("pp_no_txen", 32'(tx_en), 32'd0);
        auto_en = 1'b1;
        done_delay = 3;
        write_byte(8'h84, 1'b1);
        check("pp_count_same", 32'(count), 32'd3);
        check("pp_tx_en", 32'(tx_en), 32'd1);
        for (int i = 0; i < 15; i++) begin
            write_byte(8'h85 + 8'(i), 1'b1);
            idle(1);
        end
        wait_drain(600);
        check("pp_empty", 32'(empty), 32'd1);

        // Asynchronous reset while waiting on the transmitter
        auto_en = 1'b0;
        for (int i = 0; i < 6; i++) write_byte(8'hC0 + 8'(i), 1'b1);
        idle(2);
        check("rm_count_pre", 32'(count), 32'd5);
        @(posedge clk);
        #3;
        sb.delete();
        rst_n = 1'b0;
        #1;
        check("rm_tx_en", 32'(tx_en), 32'd0);
        check("rm_tx_data", 32'(tx_data), 32'h00);
        check("rm_count", 32'(count), 32'd0);
        check("rm_empty", 32'(empty), 32'd1);
        check("rm_full", 32'(full), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int base;
            base = n_txen;
            idle(10);
            check("rm_no_txen", 32'(n_txen - base), 32'd0);
            write_byte(8'hD1, 1'b1);
            idle(3);
            check("rm_new_txen", 32'(n_txen - base), 32'd1);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        idle(3);
        check("end_sb_empty", 32'(sb.size()), 32'd0);
        check("end_empty", 32'(empty), 32'd1);
        check("end_count", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
